// File: rtl/conv_out_packer_pkg.sv
// Shared widths, saturation bounds and FSM encoding for the convolution output packer.
package conv_out_packer_pkg;
    localparam int LANES      = 4;
    localparam int IN_W       = 16;
    localparam int OUT_W      = 8;
    localparam int BEATS      = 4;
    localparam int ADDR_WIDTH = 9;
    localparam int ROWS       = 16;
    localparam int CNT_W      = 5;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int BEAT_W     = LANES * OUT_W;
    localparam int ROW_W      = BEAT_W * BEATS;

    localparam logic signed [IN_W-1:0] SAT_U_MAX = 16'sd255;
    localparam logic signed [IN_W-1:0] SAT_S_MAX = 16'sd127;
    localparam logic signed [IN_W-1:0] SAT_S_MIN = -16'sd128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/conv_out_packer_if.sv
// Input beat stream and SRAM row-write port of the output packer.
interface conv_out_packer_if;
    import conv_out_packer_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*IN_W-1:0]   in_data;
    logic                    out_we;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic [ROW_W-1:0]        out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_we, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_we, out_addr, out_data
    );
endinterface

// File: rtl/conv_quant_lane.sv
// One lane of requantisation: optional ReLU, arithmetic right shift, saturate to a byte.
module conv_quant_lane
    import conv_out_packer_pkg::*;
(
    input  logic signed [IN_W-1:0] din,
    input  logic [3:0]             shift,
    input  logic                   relu_en,
    output logic [OUT_W-1:0]       dout
);
    logic signed [IN_W-1:0] shifted;

    assign shifted = din >>> shift;

    always_comb begin
        dout = shifted[OUT_W-1:0];
        if (relu_en) begin
            if (din[IN_W-1]) begin
                dout = '0;
            end else if (shifted > SAT_U_MAX) begin
                dout = '1;
            end
        end else begin
            if (shifted > SAT_S_MAX) begin
                dout = SAT_S_MAX[OUT_W-1:0];
            end else if (shifted < SAT_S_MIN) begin
                dout = SAT_S_MIN[OUT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/conv_out_packer.sv
// Quantises 4-lane conv results and packs BEATS beats into one SRAM row write per frame row.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | accepting beats, assembling and writing rows
//   ST_DRAIN | last row assembled, waiting for its write handshake
//   ST_DONE  | one-cycle done pulse, then back to idle
module conv_out_packer
    import conv_out_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [3:0]            shift,
    input  logic                  relu_en,
    conv_out_packer_if.slave      bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      row_cnt
);
    localparam int ASM_W = (BEATS - 1) * BEAT_W;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      LAST_ROW  = CNT_W'(ROWS - 1);

    state_t                  state;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]        rows_asm;
    logic [3:0]              shift_q;
    logic                    relu_q;
    logic [ASM_W-1:0]        asm_row;
    logic [BEAT_W-1:0]       q_beat;
    logic                    out_we_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic [ROW_W-1:0]        out_data_q;
    logic                    in_ready_c;
    logic                    accept;
    logic                    row_done;
    logic                    wr_hs;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        conv_quant_lane u_lane (
            .din     (bus.in_data[IN_W*k +: IN_W]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .dout    (q_beat[OUT_W*k +: OUT_W])
        );
    end

    // Only the row-completing beat has to wait for the output register to free up.
    assign in_ready_c = (state == ST_RUN) && !(beat_cnt == LAST_BEAT && out_we_q && !bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign row_done   = accept && (beat_cnt == LAST_BEAT);
    assign wr_hs      = out_we_q && bus.out_ready;

    assign bus.in_ready = in_ready_c;
    assign bus.out_we   = out_we_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            rows_asm   <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            asm_row    <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            row_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        shift_q    <= shift;
                        relu_q     <= relu_en;
                        out_addr_q <= base_addr;
                        beat_cnt   <= '0;
                        rows_asm   <= '0;
                        row_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    if (row_done && rows_asm == LAST_ROW) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_hs) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Earlier beats shift down so beat 0 ends up in the lowest bytes of the row.
            if (accept) begin
                beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                if (beat_cnt != LAST_BEAT) begin
                    asm_row <= {q_beat, asm_row[ASM_W-1:BEAT_W]};
                end
            end

            if (row_done) begin
                rows_asm   <= rows_asm + CNT_W'(1);
                out_we_q   <= 1'b1;
                out_data_q <= {q_beat, asm_row};
            end else if (wr_hs) begin
                out_we_q <= 1'b0;
            end

            if (wr_hs) begin
                out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
                row_cnt    <= row_cnt + CNT_W'(1);
            end
        end
    end
endmodule
